// File: rtl/abs_dif_pkg.sv
// Shared definitions for the abs_dif datapath: FSM state encodings and default operand width.
package abs_dif_pkg;

   localparam int SIZE_DEF = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SUB  = 2'd1,
      S_NEG  = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/addsub_core.sv
// SIZE-bit combinational adder shared by the subtract and negate steps of abs_dif_seq.
module addsub_core #(
   parameter int SIZE = 4
) (
   input  logic [SIZE-1:0] x,
   input  logic [SIZE-1:0] y,
   input  logic            cin,
   output logic [SIZE-1:0] s,
   output logic            co
);

   assign {co, s} = {1'b0, x} + {1'b0, y} + {{SIZE{1'b0}}, cin};

endmodule

// File: rtl/abs_dif_seq.sv
// Sequential unsigned |a-b| over one shared adder: subtract, then negate on borrow.
// Optional feature: define ABS_DIF_LT_OUT_EN to add the registered lt (a<b) output.
module abs_dif_seq
   import abs_dif_pkg::*;
#(
   parameter int SIZE = SIZE_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] d
`ifdef ABS_DIF_LT_OUT_EN
   ,
   output logic            lt
`endif
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; in_ready is high only in IDLE, out_valid only in DONE, and d is
   // held unchanged for as long as out_valid waits on out_ready.

   state_e          state_q, state_d;
   logic [SIZE-1:0] ra_q, ra_d;
   logic [SIZE-1:0] rb_q, rb_d;
   logic [SIZE-1:0] r_q, r_d;
   logic [SIZE-1:0] d_q, d_d;
   logic [SIZE-1:0] add_x, add_y, add_s;
   logic            add_cin, add_co;
`ifdef ABS_DIF_LT_OUT_EN
   logic            lt_q, lt_d;
`endif

   addsub_core #(.SIZE(SIZE)) u_addsub (
      .x   (add_x),
      .y   (add_y),
      .cin (add_cin),
      .s   (add_s),
      .co  (add_co)
   );

   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      r_d     = r_q;
      d_d     = d_q;
      add_x   = '0;
      add_y   = '0;
      add_cin = 1'b0;
`ifdef ABS_DIF_LT_OUT_EN
      lt_d    = lt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               ra_d    = a;
               rb_d    = b;
`ifdef ABS_DIF_LT_OUT_EN
               lt_d    = 1'b0;
`endif
               state_d = S_SUB;
            end
         end
         S_SUB: begin
            // ra - rb as ra + ~rb + 1; carry out means no borrow, i.e. a >= b
            add_x   = ra_q;
            add_y   = ~rb_q;
            add_cin = 1'b1;
            r_d     = add_s;
            if (add_co) begin
               d_d     = add_s;
               state_d = S_DONE;
            end else begin
`ifdef ABS_DIF_LT_OUT_EN
               lt_d    = 1'b1;
`endif
               state_d = S_NEG;
            end
         end
         S_NEG: begin
            add_x   = ~r_q;
            add_y   = '0;
            add_cin = 1'b1;
            r_d     = add_s;
            d_d     = add_s;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         r_q     <= '0;
         d_q     <= '0;
`ifdef ABS_DIF_LT_OUT_EN
         lt_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         r_q     <= r_d;
         d_q     <= d_d;
`ifdef ABS_DIF_LT_OUT_EN
         lt_q    <= lt_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign d         = d_q;
`ifdef ABS_DIF_LT_OUT_EN
   assign lt        = lt_q;
`endif

endmodule
